// File: rtl/mips_muldiv.sv
// mips_muldiv
// -----------------------------------------------------------------------------
// Iterative multiply/divide unit. It holds the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run in the background for MUL_ITER RUN cycles and then
// one FIX cycle. Any further request to this unit is refused through
// mul__stall_2a until the unit is back in IDLE.
//
// Ports
//   clk              in   clock; all state updates on the rising edge
//   rst_b            in   asynchronous active-low reset
//   mul__opcode_2a   in   MULT=0 MULTU=1 DIV=2 DIVU=3 MFHI=4 MFLO=5 MTHI=6 MTLO=7
//   mul__active_2a   in   an instruction for this unit is in execute this cycle
//   rs_data_2a       in   multiplicand / dividend / MTHI-MTLO source
//   rt_data_2a       in   multiplier / divisor
//   mul__stall_2a    out  combinational: the current request is refused
//   mul__rd_data_3a  out  registered MFHI/MFLO result
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle multiplier
//                       and go straight from IDLE to FIX. Divides are unchanged.
// -----------------------------------------------------------------------------
module mips_muldiv #(
    parameter int MUL_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [2:0]  mul__opcode_2a,
    input  logic        mul__active_2a,
    input  logic [31:0] rs_data_2a,
    input  logic [31:0] rt_data_2a,
    output logic        mul__stall_2a,
    output logic [31:0] mul__rd_data_3a
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;
    localparam logic [2:0] OP_MTHI = 3'd6;
    localparam logic [2:0] OP_MTLO = 3'd7;
    localparam logic [5:0] LAST_ITER = 6'(MUL_ITER - 1);

    state_t state_q, state_d;

    logic [5:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] rd_q;

    // Latched operation context for the background operation
    logic        op_div_q;
    logic        neg_q;        // negate product or quotient in FIX
    logic        neg_r_q;      // negate remainder in FIX
    logic        div_zero_q;
    logic [31:0] rs_q;         // original dividend, returned in HI on divide by zero
    logic [31:0] opnd_q;       // |multiplicand| or |divisor|

    // Shared shift register: {33-bit upper, 32-bit lower}.
    // Multiply: upper accumulates the partial product, lower holds the
    // multiplier and fills with product bits. Divide: upper is the partial
    // remainder, lower holds the dividend and fills with quotient bits.
    logic [64:0] acc_q;

    logic        accept;
    logic        start_op;
    logic        op_div;
    logic        op_signed;
    logic [31:0] abs_rs, abs_rt;

    assign accept    = mul__active_2a & ~mul__stall_2a;
    assign start_op  = accept & ~mul__opcode_2a[2];
    assign op_div    = mul__opcode_2a[1];
    assign op_signed = ~mul__opcode_2a[0];
    assign abs_rs    = (op_signed & rs_data_2a[31]) ? (32'd0 - rs_data_2a) : rs_data_2a;
    assign abs_rt    = (op_signed & rt_data_2a[31]) ? (32'd0 - rt_data_2a) : rt_data_2a;

    // One shift-add multiply step: add the multiplicand when the current
    // multiplier bit is set, then shift the whole register right by one.
    logic [32:0] mul_sum;
    logic [64:0] mul_next;
    assign mul_sum  = acc_q[0] ? (acc_q[64:32] + {1'b0, opnd_q}) : acc_q[64:32];
    assign mul_next = {1'b0, mul_sum, acc_q[31:1]};

    // One restoring divide step: shift the next dividend bit into the
    // remainder, try to subtract the divisor and keep the result only if it
    // did not go negative. The partial remainder stays below 2^32, so the
    // 33-bit difference sign tells us whether the subtraction fits.
    logic [32:0] rem_shift;
    logic [32:0] div_diff;
    logic [64:0] div_next;
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = rem_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[32] ? {rem_shift, acc_q[30:0], 1'b0}
                                    : {div_diff,  acc_q[30:0], 1'b1};

    // Sign correction applied in FIX
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_q   ? (64'd0 - acc_q[63:0])  : acc_q[63:0];
    assign quo_fix  = neg_q   ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem_fix  = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, abs_rs} * {32'd0, abs_rt};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall. Stall depends only on active and the state
    // register, never on operand data.
    always_comb begin
        state_d       = state_q;
        mul__stall_2a = mul__active_2a & (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_op) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_d = op_div ? ST_RUN : ST_FIX;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: operation launch, iteration, HI/LO write-back and the
    // MT/MF register accesses. MT/MF only happen in IDLE, so they can
    // never collide with the FIX write.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q      <= 6'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            rd_q       <= 32'd0;
            op_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            rs_q       <= 32'd0;
            opnd_q     <= 32'd0;
            acc_q      <= 65'd0;
        end else begin
            if (start_op) begin
                op_div_q   <= op_div;
                neg_q      <= op_signed & (rs_data_2a[31] ^ rt_data_2a[31]);
                neg_r_q    <= op_signed & rs_data_2a[31];
                div_zero_q <= op_div & (rt_data_2a == 32'd0);
                rs_q       <= rs_data_2a;
                cnt_q      <= 6'd0;
                opnd_q     <= op_div ? abs_rt : abs_rs;
                acc_q      <= {33'd0, (op_div ? abs_rs : abs_rt)};
`ifdef MULDIV_FAST_MUL_EN
                if (!op_div) begin
                    acc_q <= {1'b0, fast_prod};
                end
`endif
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + 6'd1;
                acc_q <= op_div_q ? div_next : mul_next;
            end

            if (state_q == ST_FIX) begin
                if (!op_div_q) begin
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
                end else if (div_zero_q) begin
                    hi_q <= rs_q;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end

            if (accept) begin
                case (mul__opcode_2a)
                    OP_MFHI: rd_q <= hi_q;
                    OP_MFLO: rd_q <= lo_q;
                    OP_MTHI: hi_q <= rs_data_2a;
                    OP_MTLO: lo_q <= rs_data_2a;
                    default: ;
                endcase
            end
        end
    end

    assign mul__rd_data_3a = rd_q;

endmodule
